cpu_phase_sequencer: RTL and testbench
======================================

// Module: cpu_phase_sequencer
// PURPOSE
//  Multicycle control FSM for the CPU core. Sequences each instruction through FETCH, DECODE, EXEC and WRITEBACK.
//  Emits one-hot phase enables: ex_en drives the exec stage's clk_ex; wb_en/reg_we drive register-file writeback.
//  Supports run, single-step, halt request, illegal-opcode trap and fetch-timeout trap.
// PARAMETERS
//  CNT_W        16   width of retire_cnt
//  FETCH_TMO    8    max FETCH cycles waiting on mem_ready before timeout trap (>=1)
// PORTS
//  clk          in   1      single system clock, all logic on posedge
//  reset        in   1      synchronous, active-low; sampled on posedge clk
//  run          in   1      level: 1 = execute continuously
//  step         in   1      pulse: execute exactly one instruction from IDLE
//  halt_req     in   1      level/pulse: stop after current instruction retires
//  clear        in   1      pulse: leave HALT, clear trap flags, go IDLE
//  mem_ready    in   1      instruction memory data valid this cycle
//  op_code      in   4      opcode field of fetched instruction
//  fetch_en     out  1      high every FETCH cycle (PC -> memory, IR load on mem_ready)
//  dec_en       out  1      high in DECODE (register-file read)
//  ex_en        out  1      high in EXEC (one clk_ex edge for exec stage)
//  wb_en        out  1      high in WB
//  reg_we       out  1      register-file write enable, WB of a writing opcode only
//  busy         out  1      1 in FETCH/DECODE/EXEC/WB
//  halted       out  1      1 in HALT
//  illegal      out  1      sticky: trapped on undefined opcode
//  timeout      out  1      sticky: trapped on fetch timeout
//  retire_cnt   out  CNT_W  instructions retired, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; all outputs 0; retire_cnt=0; opcode latch=0; fetch wait counter=0.
//  States: IDLE, FETCH, DECODE, EXEC, WB, HALT. Enables are Moore outputs of state, registered, one-hot.
//  IDLE: halt_req -> HALT; else run -> FETCH; else step -> FETCH with step_mode=1; else stay.
//  FETCH: fetch_en=1. mem_ready -> DECODE, opcode latched from op_code on that edge.
//   Wait counter increments each FETCH cycle without mem_ready; at FETCH_TMO cycles -> HALT, timeout=1.
//   Min FETCH length 1 cycle (mem_ready already high on entry).
//  DECODE (1 cycle): dec_en=1. Latched opcode 0000..0100 (MOV,ADD,SUB,LDL,LDH) -> EXEC.
//   1111 (HLT) -> HALT, no retire. Any other value -> HALT, illegal=1, no retire.
//  EXEC (1 cycle): ex_en=1 -> WB.
//  WB (1 cycle): wb_en=1; reg_we=1 for 0000..0100; retire_cnt+1 on exit edge.
//   Then: halt_req (seen at any time since FETCH entry, latched) -> HALT;
//   else step_mode -> IDLE (step_mode cleared); else run -> FETCH; else IDLE.
//  Instruction latency: 4 cycles with zero-wait fetch; retire rate 1 per 4 cycles while run=1.
//  HALT: halted=1; ignores run/step/halt_req; clear -> IDLE, clears illegal/timeout/halt latch. retire_cnt kept.
//  Priority at a decision point: reset > trap > halt_req > step_mode > run > step.
//  run dropping mid-instruction: instruction completes through WB, then IDLE. step while busy: ignored.
//  retire_cnt wrap: all-ones + 1 = 0, no flag.
//  Reset mid-instruction: abort immediately, no reg_we, counters to 0.
//  FETCH_TMO wait counter resets on every FETCH entry.
// TESTING
//  1. reset=0 two cycles, then run=1, mem_ready=1, op_code=0001 for 3 instructions ->
//     fetch/dec/ex/wb strobes 1 cycle each in order; reg_we in WB; retire_cnt=3 after 12 cycles.
//  2. IDLE, step pulse, op_code=0011 -> exactly one FETCH..WB then IDLE, retire_cnt=1; second step pulse while busy ignored.
//  3. run=1, op_code=0111 -> HALT after DECODE, illegal=1, no ex_en/reg_we, retire_cnt unchanged;
//     clear -> IDLE, illegal=0.
//  4. run=1, mem_ready=0 with FETCH_TMO=8 -> fetch_en high 8 cycles, then HALT, timeout=1;
//     repeat with mem_ready on the 8th cycle -> DECODE, no trap.
//  5. halt_req pulse during EXEC -> WB completes with reg_we=1 and retire, then HALT.
//     reset=0 during EXEC -> next cycle IDLE, all outputs 0.
//  6. CNT_W=4, run 16 ADD instructions -> retire_cnt wraps 15 -> 0.
//     op_code=1111 -> HALT with illegal=0.

Source files
------------

// File: rtl/cpu_phase_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/WB sequencer; 4 cycles per instruction with zero-wait fetch.
// Stalls in FETCH until mem_ready, trapping to HALT after FETCH_TMO waiting cycles.
module cpu_phase_sequencer #(
  parameter int CNT_W     = 16,
  parameter int FETCH_TMO = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             clear,
  input  logic             mem_ready,
  input  logic [3:0]       op_code,
  output logic             fetch_en,
  output logic             dec_en,
  output logic             ex_en,
  output logic             wb_en,
  output logic             reg_we,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam int              WAIT_W    = $clog2(FETCH_TMO + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TMO - 1);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [3:0]        opcode_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              step_mode;
  logic              halt_lat;
  logic              op_writes;
  logic              op_hlt;
  logic              cur_busy;
  logic              nxt_busy;

  assign op_writes = (opcode_q <= 4'd4);
  assign op_hlt    = (opcode_q == 4'hF);
  assign cur_busy  = (state == S_FETCH) || (state == S_DECODE) ||
                     (state == S_EXEC)  || (state == S_WB);
  assign nxt_busy  = (state_nxt == S_FETCH) || (state_nxt == S_DECODE) ||
                     (state_nxt == S_EXEC)  || (state_nxt == S_WB);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (halt_req)         state_nxt = S_HALT;
        else if (run || step) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready)                 state_nxt = S_DECODE;
        else if (wait_cnt == WAIT_LAST) state_nxt = S_HALT;
      end
      S_DECODE: state_nxt = op_writes ? S_EXEC : S_HALT;
      S_EXEC:   state_nxt = S_WB;
      S_WB: begin
        // A halt request raised anywhere during the instruction wins here.
        if (halt_lat || halt_req) state_nxt = S_HALT;
        else if (step_mode)       state_nxt = S_IDLE;
        else if (run)             state_nxt = S_FETCH;
        else                      state_nxt = S_IDLE;
      end
      S_HALT: if (clear) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      opcode_q   <= 4'd0;
      wait_cnt   <= '0;
      step_mode  <= 1'b0;
      halt_lat   <= 1'b0;
      fetch_en   <= 1'b0;
      dec_en     <= 1'b0;
      ex_en      <= 1'b0;
      wb_en      <= 1'b0;
      reg_we     <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
      timeout    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state    <= state_nxt;
      fetch_en <= (state_nxt == S_FETCH);
      dec_en   <= (state_nxt == S_DECODE);
      ex_en    <= (state_nxt == S_EXEC);
      wb_en    <= (state_nxt == S_WB);
      reg_we   <= (state_nxt == S_WB) && op_writes;
      busy     <= nxt_busy;
      halted   <= (state_nxt == S_HALT);

      if (state_nxt == S_FETCH && state != S_FETCH)
        wait_cnt <= '0;
      else if (state == S_FETCH && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;

      if (state == S_FETCH && mem_ready)
        opcode_q <= op_code;

      // Step mode only when step, not run, launched the instruction.
      if (state == S_IDLE && state_nxt == S_FETCH)
        step_mode <= !run;
      else if (!nxt_busy)
        step_mode <= 1'b0;

      if (state == S_WB || !nxt_busy)
        halt_lat <= 1'b0;
      else if (cur_busy)
        halt_lat <= halt_lat | halt_req;

      if (state == S_WB)
        retire_cnt <= retire_cnt + 1'b1;

      if (state == S_DECODE && !op_writes && !op_hlt)
        illegal <= 1'b1;
      else if (state == S_HALT && clear)
        illegal <= 1'b0;

      if (state == S_FETCH && !mem_ready && wait_cnt == WAIT_LAST)
        timeout <= 1'b1;
      else if (state == S_HALT && clear)
        timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Randomized directed bench for cpu_phase_sequencer against an instruction-level model.
module tb_cpu_phase_sequencer;

  localparam int TMO = 8;

  typedef enum int {P_IDLE, P_FETCH, P_DEC, P_EX, P_WB, P_HALT} ph_t;

  logic       clk = 1'b0;
  logic       reset, run, step, halt_req, clear, mem_ready;
  logic [3:0] op_code;
  logic       fetch_en, dec_en, ex_en, wb_en, reg_we, busy, halted, illegal, timeout;
  logic [3:0] retire_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  bit exp_ill = 0;
  bit exp_tmo = 0;
  bit step_mode = 0;

  cpu_phase_sequencer #(.CNT_W(4), .FETCH_TMO(TMO)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .clear(clear), .mem_ready(mem_ready), .op_code(op_code),
    .fetch_en(fetch_en), .dec_en(dec_en), .ex_en(ex_en), .wb_en(wb_en),
    .reg_we(reg_we), .busy(busy), .halted(halted), .illegal(illegal),
    .timeout(timeout), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_ph(input string tag, input ph_t ph, input bit we);
    logic [6:0] exp_v, obs_v;
    logic [31:0] obs_c, exp_c;
    exp_v = {ph == P_FETCH, ph == P_DEC, ph == P_EX, ph == P_WB, we,
             (ph == P_FETCH) || (ph == P_DEC) || (ph == P_EX) || (ph == P_WB),
             ph == P_HALT};
    obs_v = {fetch_en, dec_en, ex_en, wb_en, reg_we, busy, halted};
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s strobes got %b want %b", tag, obs_v, exp_v);
    end
    obs_c = {28'd0, retire_cnt};
    exp_c = 32'(exp_cnt % 16);
    total++;
    assert (obs_c === exp_c) else begin
      bad++;
      $error("FAIL %s retire_cnt got %0d want %0d", tag, obs_c, exp_c);
    end
    total++;
    assert ({illegal, timeout} === {exp_ill, exp_tmo}) else begin
      bad++;
      $error("FAIL %s ill/tmo got %b%b want %b%b", tag, illegal, timeout, exp_ill, exp_tmo);
    end
  endtask

  // Runs one instruction from the FETCH phase; w = cycles mem_ready stays low,
  // halt_ph = phase at which a halt_req pulse is issued (1 fetch, 2 decode, 3 exec).
  task automatic do_instr(input logic [3:0] op, input int w, input int halt_ph, input bit run_wb);
    bit got, hlt_seen;
    got = 0;
    hlt_seen = 0;
    for (int i = 0; i < TMO && !got; i++) begin
      check_ph("fetch", P_FETCH, 0);
      mem_ready = (i == w);
      op_code   = (i == w) ? op : 4'($urandom);
      halt_req  = (halt_ph == 1 && i == 0);
      if (halt_req) hlt_seen = 1;
      got = (i == w);
      cyc();
      halt_req = 0;
    end
    if (!got) begin
      exp_tmo = 1;
      step_mode = 0;
      check_ph("fetch_tmo", P_HALT, 0);
      return;
    end
    check_ph("decode", P_DEC, 0);
    mem_ready = 1'($urandom);
    op_code   = 4'($urandom);
    step      = 1'($urandom);
    halt_req  = (halt_ph == 2);
    if (halt_req) hlt_seen = 1;
    cyc();
    halt_req = 0;
    step = 0;
    if (op > 4) begin
      if (op != 4'hF) exp_ill = 1;
      step_mode = 0;
      check_ph("dec_trap", P_HALT, 0);
      return;
    end
    check_ph("exec", P_EX, 0);
    halt_req = (halt_ph == 3);
    if (halt_req) hlt_seen = 1;
    cyc();
    halt_req = 0;
    check_ph("wb", P_WB, 1);
    run = run_wb;
    cyc();
    exp_cnt++;
    if (hlt_seen) begin
      step_mode = 0;
      check_ph("wb_halt", P_HALT, 0);
    end else if (step_mode) begin
      step_mode = 0;
      check_ph("wb_step_idle", P_IDLE, 0);
    end else if (run_wb) begin
      check_ph("wb_next", P_FETCH, 0);
    end else begin
      check_ph("wb_idle", P_IDLE, 0);
    end
  endtask

  task automatic do_clear();
    run = 0;
    clear = 1;
    cyc();
    clear = 0;
    exp_ill = 0;
    exp_tmo = 0;
    check_ph("clear", P_IDLE, 0);
  endtask

  initial begin
    reset = 0; run = 0; step = 0; halt_req = 0; clear = 0; mem_ready = 0; op_code = 4'd0;
    @(negedge clk);
    cyc();
    cyc();
    check_ph("reset", P_IDLE, 0);
    reset = 1;
    cyc();
    check_ph("idle_hold", P_IDLE, 0);

    // Continuous run, three ADDs with zero-wait fetch.
    run = 1;
    cyc();
    do_instr(4'd1, 0, 0, 1);
    do_instr(4'd1, 0, 0, 1);
    do_instr(4'd1, 0, 0, 0);

    // Single step; run raised during WB must not override step mode.
    step = 1;
    cyc();
    step = 0;
    step_mode = 1;
    do_instr(4'd3, 0, 0, 1);
    cyc();
    check_ph("idle_run", P_FETCH, 0);
    do_instr(4'd4, 1, 0, 0);

    // Illegal opcode, HALT ignores run/step/halt_req, then clear.
    run = 1;
    cyc();
    do_instr(4'd7, 0, 0, 1);
    step = 1; halt_req = 1;
    cyc();
    check_ph("halt_sticky", P_HALT, 0);
    step = 0; halt_req = 0;
    do_clear();

    // Fetch timeout, then mem_ready on the last allowed cycle.
    run = 1;
    cyc();
    do_instr(4'd2, TMO + 3, 0, 1);
    do_clear();
    run = 1;
    cyc();
    do_instr(4'd2, TMO - 1, 0, 0);

    // Halt requests during EXEC and FETCH retire the instruction, then HALT.
    run = 1;
    cyc();
    do_instr(4'd1, 1, 3, 1);
    do_clear();
    run = 1;
    cyc();
    do_instr(4'd0, 2, 1, 1);
    do_clear();

    // halt_req from IDLE.
    halt_req = 1;
    cyc();
    halt_req = 0;
    check_ph("idle_halt", P_HALT, 0);
    do_clear();

    // Reset during EXEC aborts the instruction.
    run = 1; mem_ready = 1; op_code = 4'd1;
    cyc();
    check_ph("rst_fetch", P_FETCH, 0);
    cyc();
    check_ph("rst_dec", P_DEC, 0);
    cyc();
    check_ph("rst_exec", P_EX, 0);
    reset = 0; run = 0;
    cyc();
    reset = 1;
    exp_cnt = 0;
    check_ph("rst_abort", P_IDLE, 0);

    // Sixteen ADDs wrap the 4-bit retire counter back to 0.
    run = 1;
    cyc();
    for (int k = 0; k < 16; k++) do_instr(4'd1, 0, 0, 1);
    total++;
    assert (retire_cnt === 4'd0) else begin
      bad++;
      $error("FAIL wrap retire_cnt got %0d want 0", retire_cnt);
    end

    // Random legal instructions with random fetch waits, then HLT.
    for (int k = 0; k < 24; k++)
      do_instr(4'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 0, 1);
    do_instr(4'hF, int'($urandom_range(0, 3)), 0, 1);
    do_clear();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
